// File: rtl/regfile_pkg.sv
// Shared codes and constants for the register-file operation controller.
package regfile_pkg;

  localparam logic [1:0] OP_VADD  = 2'd0;
  localparam logic [1:0] OP_VSUB  = 2'd1;
  localparam logic [1:0] OP_ACCUM = 2'd2;
  localparam logic [1:0] OP_COPY  = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_ACC   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [2:0] SEL_RADDR1 = 3'd0;
  localparam logic [2:0] SEL_RADDR2 = 3'd1;
  localparam logic [2:0] SEL_WADDR  = 3'd2;
  localparam logic [2:0] SEL_WDATA  = 3'd3;
  localparam logic [2:0] SEL_COUNT  = 3'd4;

  localparam int unsigned DISP_REG_BASE = 8;

  localparam logic [5:0] DISP_RADD1 = 6'd1;
  localparam logic [5:0] DISP_RDAT1 = 6'd2;
  localparam logic [5:0] DISP_RADD2 = 6'd3;
  localparam logic [5:0] DISP_RDAT2 = 6'd4;
  localparam logic [5:0] DISP_WADDR = 6'd5;
  localparam logic [5:0] DISP_WDATA = 6'd6;
  localparam logic [5:0] DISP_COUNT = 6'd7;

  localparam logic [39:0] NAME_RADD1 = "RADD1";
  localparam logic [39:0] NAME_RDAT1 = "RDAT1";
  localparam logic [39:0] NAME_RADD2 = "RADD2";
  localparam logic [39:0] NAME_RDAT2 = "RDAT2";
  localparam logic [39:0] NAME_WADDR = "WADDR";
  localparam logic [39:0] NAME_WDATA = "WDATA";
  localparam logic [39:0] NAME_COUNT = "COUNT";
  localparam logic [23:0] NAME_REG   = "REG";

  // "REGdd" label for a register index (two decimal digits)
  function automatic logic [39:0] reg_name(input logic [5:0] idx);
    logic [7:0] tens;
    logic [7:0] ones;
    tens = 8'h30 + 8'(idx / 6'd10);
    ones = 8'h30 + 8'(idx % 6'd10);
    return {NAME_REG, tens, ones};
  endfunction

endpackage

// File: rtl/regfile_np.sv
// Register file: three combinational read ports, one clocked write port, R0 reads as zero.
module regfile_np #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [AW-1:0] ra3,
  output logic [DW-1:0] rd1_c,
  output logic [DW-1:0] rd2_c,
  output logic [DW-1:0] rd3_c
);
  localparam int unsigned NREG = 2**AW;

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (we && (wa != '0)) mem[wa] <= wd;
  end

  assign rd1_c = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2_c = (ra2 == '0) ? '0 : mem[ra2];
  assign rd3_c = (ra3 == '0) ? '0 : mem[ra3];

endmodule

// File: rtl/regfile_op_ctrl.sv
// Register-file controller: manual touchscreen access, range operation sequencer and LCD display mux.
module regfile_op_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wen_sw,
  input  logic [2:0]  input_sel,
  input  logic        input_valid,
  input  logic [31:0] input_value,
  input  logic        op_start,
  input  logic [1:0]  op_mode,
  output logic        busy,
  output logic        done,
  input  logic [5:0]  display_number,
  output logic        display_valid,
  output logic [39:0] display_name,
  output logic [31:0] display_value,
  output logic [4:0]  led_sel
);
  localparam int unsigned NREG = 2**AW;
  localparam int unsigned CW   = AW + 1;

  logic [2:0]    state_q, state_nxt;
  logic [AW-1:0] raddr1_q, raddr2_q, waddr_q;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] count_q;
  logic [1:0]    mode_q;
  logic [AW-1:0] op_ra1_q, op_ra2_q, op_wa_q;
  logic [CW-1:0] op_cnt_q, idx_q, idx_nxt, idx_inc_c;
  logic [DW-1:0] a_q, b_q, acc_q, a_nxt, b_nxt, acc_nxt;
  logic          start_c, active_c, last_c, busy_nxt, done_nxt;
  logic [AW-1:0] elem_c;
  logic          rf_we_c;
  logic [AW-1:0] rf_wa_c, rf_ra1_c, rf_ra2_c, rf_ra3_c;
  logic [DW-1:0] rf_wd_c, rf_rd1_c, rf_rd2_c, rf_rd3_c;
  logic          disp_valid_c;
  logic [39:0]   disp_name_c;
  logic [31:0]   disp_value_c;
  logic [4:0]    led_sel_c;

  regfile_np #(.DW(DW), .AW(AW)) u_rf (
    .clk   (clk),
    .we    (rf_we_c & resetn),
    .wa    (rf_wa_c),
    .wd    (rf_wd_c),
    .ra1   (rf_ra1_c),
    .ra2   (rf_ra2_c),
    .ra3   (rf_ra3_c),
    .rd1_c (rf_rd1_c),
    .rd2_c (rf_rd2_c),
    .rd3_c (rf_rd3_c)
  );

  // Operand ports follow the element index while sequencing, the entered addresses otherwise
  assign active_c  = state_q inside {ST_READ, ST_WRITE, ST_ACC};
  assign elem_c    = idx_q[AW-1:0];
  assign idx_inc_c = idx_q + CW'(1);
  assign last_c    = (idx_inc_c == op_cnt_q);
  assign rf_ra1_c  = active_c ? (op_ra1_q + elem_c) : raddr1_q;
  assign rf_ra2_c  = active_c ? (op_ra2_q + elem_c) : raddr2_q;
  assign rf_ra3_c  = AW'(display_number - 6'(DISP_REG_BASE));

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    acc_nxt   = acc_q;
    start_c   = 1'b0;
    rf_we_c   = 1'b0;
    rf_wa_c   = waddr_q;
    rf_wd_c   = wdata_q;
    case (state_q)
      ST_IDLE: begin
        rf_we_c = wen_sw;
        if (op_start) begin
          start_c = 1'b1;
          idx_nxt = '0;
          if (count_q == '0) begin
            state_nxt = ST_DONE;
          end else if (op_mode == OP_ACCUM) begin
            acc_nxt   = '0;
            state_nxt = ST_ACC;
          end else begin
            state_nxt = ST_READ;
          end
        end
      end
      ST_READ: begin
        a_nxt     = rf_rd1_c;
        b_nxt     = rf_rd2_c;
        state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        rf_we_c = 1'b1;
        if (mode_q == OP_ACCUM) begin
          rf_wa_c   = op_wa_q;
          rf_wd_c   = acc_q;
          state_nxt = ST_DONE;
        end else begin
          rf_wa_c = op_wa_q + elem_c;
          case (mode_q)
            OP_VADD: rf_wd_c = a_q + b_q;
            OP_VSUB: rf_wd_c = a_q - b_q;
            default: rf_wd_c = a_q;
          endcase
          idx_nxt   = idx_inc_c;
          state_nxt = last_c ? ST_DONE : ST_READ;
        end
      end
      ST_ACC: begin
        acc_nxt   = acc_q + rf_rd1_c;
        idx_nxt   = idx_inc_c;
        state_nxt = last_c ? ST_WRITE : ST_ACC;
      end
      ST_DONE: begin
        rf_we_c   = wen_sw;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = state_nxt inside {ST_READ, ST_WRITE, ST_ACC};
    done_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Touchscreen-entered control fields; frozen while the sequencer owns the file
  always_ff @(posedge clk) begin
    if (!resetn) begin
      raddr1_q <= '0;
      raddr2_q <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      count_q  <= '0;
    end else if (!active_c && input_valid) begin
      case (input_sel)
        SEL_RADDR1: raddr1_q <= AW'(input_value);
        SEL_RADDR2: raddr2_q <= AW'(input_value);
        SEL_WADDR:  waddr_q  <= AW'(input_value);
        SEL_WDATA:  wdata_q  <= DW'(input_value);
        SEL_COUNT:  count_q  <= CW'(input_value);
        default: ;
      endcase
    end
  end

  // Operation snapshot taken from the pre-edge field values at start
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode_q   <= OP_VADD;
      op_ra1_q <= '0;
      op_ra2_q <= '0;
      op_wa_q  <= '0;
      op_cnt_q <= '0;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
    end else begin
      if (start_c) begin
        mode_q   <= op_mode;
        op_ra1_q <= raddr1_q;
        op_ra2_q <= raddr2_q;
        op_wa_q  <= waddr_q;
        op_cnt_q <= count_q;
      end
      idx_q <= idx_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      acc_q <= acc_nxt;
    end
  end

  always_comb begin
    disp_valid_c = 1'b0;
    disp_name_c  = '0;
    disp_value_c = '0;
    case (display_number)
      DISP_RADD1: begin disp_valid_c = 1'b1; disp_name_c = NAME_RADD1; disp_value_c = 32'(raddr1_q); end
      DISP_RDAT1: begin disp_valid_c = 1'b1; disp_name_c = NAME_RDAT1; disp_value_c = 32'(rf_rd1_c); end
      DISP_RADD2: begin disp_valid_c = 1'b1; disp_name_c = NAME_RADD2; disp_value_c = 32'(raddr2_q); end
      DISP_RDAT2: begin disp_valid_c = 1'b1; disp_name_c = NAME_RDAT2; disp_value_c = 32'(rf_rd2_c); end
      DISP_WADDR: begin disp_valid_c = 1'b1; disp_name_c = NAME_WADDR; disp_value_c = 32'(waddr_q); end
      DISP_WDATA: begin disp_valid_c = 1'b1; disp_name_c = NAME_WDATA; disp_value_c = 32'(wdata_q); end
      DISP_COUNT: begin disp_valid_c = 1'b1; disp_name_c = NAME_COUNT; disp_value_c = 32'(count_q); end
      default: begin
        if ((display_number >= 6'(DISP_REG_BASE)) &&
            (32'(display_number) < DISP_REG_BASE + NREG)) begin
          disp_valid_c = 1'b1;
          disp_name_c  = reg_name(display_number - 6'(DISP_REG_BASE));
          disp_value_c = 32'(rf_rd3_c);
        end
      end
    endcase
  end

  always_comb begin
    led_sel_c = '0;
    if (input_sel <= SEL_COUNT) led_sel_c = 5'(5'd1 << input_sel);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      display_valid <= 1'b0;
      display_name  <= '0;
      display_value <= '0;
      led_sel       <= '0;
    end else begin
      display_valid <= disp_valid_c;
      display_name  <= disp_name_c;
      display_value <= disp_value_c;
      led_sel       <= led_sel_c;
    end
  end

endmodule
